// File: rtl/spi_slave_sync_if.sv
// SPI responder bus: serial pins, mode selects and the parallel tx/rx handshake.
interface spi_slave_sync_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  cpol;
    logic                  cpha;
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_load;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  frame_err;
    logic [1:0]            slave_state;

    modport slave (
        input  cpol, cpha, sclk, cs_n, mosi, tx_data, tx_load,
        output miso, tx_ready, rx_data, rx_valid, frame_err, slave_state
    );

    modport master (
        output cpol, cpha, sclk, cs_n, mosi, tx_data, tx_load,
        input  miso, tx_ready, rx_data, rx_valid, frame_err, slave_state
    );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled on the system clock: all four modes, MSB first,
// back-to-back words, pending tx word with load handshake.
module spi_slave_sync #(
    parameter int unsigned          DATA_WIDTH  = 8,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = '0
) (
    input  logic          clk,
    input  logic          reset,
    spi_slave_sync_if.slave spi
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned SET_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_WAIT_CS = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0]  pend_q, pend_d;
    logic                   pend_full_q, pend_full_d;
    logic [SET_W-1:0]       settle_q, settle_d;
    logic                   armed_q, armed_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, consume;
    logic [DATA_WIDTH-1:0] rx_word, reload_word;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_edge   = sclk_s ^ sclk_prev_q;
    assign lead_edge   = sclk_edge & (sclk_prev_q == cpol_q);
    assign trail_edge  = sclk_edge & (sclk_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q & cs_s;
    assign rx_word     = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
    assign reload_word = pend_full_q ? pend_q : IDLE_BYTE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            settle_q    <= SET_W'(SYNC_STAGES);
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        settle_d    = (settle_q != '0) ? settle_q - 1'b1 : settle_q;
        armed_d     = armed_q;
        consume     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // After reset, wait for the cs_n pipeline to hold the real pin
                // level so a master already mid-frame is not mistaken for a start.
                if (!armed_q) begin
                    if (settle_q == '0) begin
                        armed_d = 1'b1;
                        if (!cs_s) state_d = ST_WAIT_CS;
                    end
                end else if (cs_fall) begin
                    cpol_d     = spi.cpol;
                    cpha_d     = spi.cpha;
                    tx_shift_d = reload_word;
                    consume    = 1'b1;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (cs_rise) begin
                    frame_err_d = (bit_cnt_q != '0);
                    state_d     = ST_IDLE;
                end else if (sample_edge) begin
                    rx_shift_d = rx_word;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        tx_shift_d = reload_word;
                        consume    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_edge && bit_cnt_q != '0) begin
                    // Shift edge at count 0 is the word's first: MSB is already out.
                    tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            ST_WAIT_CS: begin
                if (cs_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A reload frees the pending register in the same cycle it may be refilled.
        if (consume) pend_full_d = 1'b0;
        if (spi.tx_load && (!pend_full_q || consume)) begin
            pend_d      = spi.tx_data;
            pend_full_d = 1'b1;
        end
    end

    assign spi.miso        = (state_q == ST_XFER) & tx_shift_q[DATA_WIDTH-1];
    assign spi.tx_ready    = ~pend_full_q;
    assign spi.rx_data     = rx_data_q;
    assign spi.rx_valid    = rx_valid_q;
    assign spi.frame_err   = frame_err_q;
    assign spi.slave_state = state_q;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: behavioural SPI master plus rx/frame_err monitor.
module tb_spi_slave_sync;
    localparam int HP = 10;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rx_cnt = 0;
    int   fe_cnt = 0;
    int   valid_cyc = 0;
    int   last_edge_cyc = 0;
    logic [7:0] rx_hist [0:31];
    logic m_cpol = 1'b0;
    logic m_cpha = 1'b0;
    logic first_miso;
    logic [7:0] mi, mi2;
    int   rx_before;

    spi_slave_sync_if #(.DATA_WIDTH(8)) bus ();

    spi_slave_sync #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2),
        .IDLE_BYTE  (8'h00)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .spi  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            if (rx_cnt < 32) rx_hist[rx_cnt] = bus.rx_data;
            rx_cnt++;
            valid_cyc = cyc;
        end
        if (bus.frame_err) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic p, input logic h);
        m_cpol   = p;
        m_cpha   = h;
        bus.cpol = p;
        bus.cpha = h;
        bus.sclk = p;
        wait_clk(8);
    endtask

    task automatic load(input logic [7:0] d);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        wait_clk(1);
        bus.tx_load = 1'b0;
    endtask

    task automatic spi_word(input logic [7:0] mo, input int nbits, output logic [7:0] mo_rx);
        mo_rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!m_cpha) begin
                bus.mosi = mo[i];
                wait_clk(HP);
                mo_rx[i] = bus.miso;
                if (i == 7) first_miso = bus.miso;
                bus.sclk = ~m_cpol;
                last_edge_cyc = cyc;
                wait_clk(HP);
                bus.sclk = m_cpol;
            end else begin
                wait_clk(HP);
                if (i == 7) first_miso = bus.miso;
                bus.sclk = ~m_cpol;
                bus.mosi = mo[i];
                wait_clk(HP);
                mo_rx[i] = bus.miso;
                bus.sclk = m_cpol;
                last_edge_cyc = cyc;
            end
        end
    endtask

    task automatic cs_high();
        wait_clk(HP);
        bus.cs_n = 1'b1;
        wait_clk(2 * HP);
    endtask

    initial begin
        reset       = 1'b1;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.sclk    = 1'b0;
        bus.cs_n    = 1'b1;
        bus.mosi    = 1'b0;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(5);

        chk("rst_miso",      32'(bus.miso), 32'd0);
        chk("rst_tx_ready",  32'(bus.tx_ready), 32'd1);
        chk("rst_rx_data",   32'(bus.rx_data), 32'h00);
        chk("rst_rx_valid",  32'(bus.rx_valid), 32'd0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
        chk("rst_state",     32'(bus.slave_state), 32'd0);

        // Mode 0
        set_mode(1'b0, 1'b0);
        load(8'hD5);
        chk("m0_tx_ready_low", 32'(bus.tx_ready), 32'd0);
        rx_before = rx_cnt;
        bus.cs_n = 1'b0;
        spi_word(8'h3C, 8, mi);
        chk("m0_state_xfer", 32'(bus.slave_state), 32'd1);
        cs_high();
        chk("m0_miso_byte", 32'(mi), 32'hD5);
        chk("m0_rx_data",   32'(bus.rx_data), 32'h3C);
        chk("m0_rx_pulses", 32'(rx_cnt - rx_before), 32'd1);
        chk("m0_rx_latency", 32'(valid_cyc - last_edge_cyc), 32'd3);
        chk("m0_frame_err", 32'(fe_cnt), 32'd0);
        chk("m0_tx_ready_high", 32'(bus.tx_ready), 32'd1);
        chk("m0_state_idle", 32'(bus.slave_state), 32'd0);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            load(8'h24);
            rx_before = rx_cnt;
            bus.cs_n = 1'b0;
            spi_word(8'hDB, 8, mi);
            cs_high();
            chk($sformatf("m%0d_miso_byte", m), 32'(mi), 32'h24);
            chk($sformatf("m%0d_rx_data", m), 32'(bus.rx_data), 32'hDB);
            chk($sformatf("m%0d_rx_pulses", m), 32'(rx_cnt - rx_before), 32'd1);
            chk($sformatf("m%0d_first_miso", m), 32'(first_miso), 32'd0);
        end
        chk("m123_frame_err", 32'(fe_cnt), 32'd0);

        // Two-word frame in mode 0
        set_mode(1'b0, 1'b0);
        load(8'hA5);
        rx_before = rx_cnt;
        bus.cs_n = 1'b0;
        wait_clk(5);
        chk("two_tx_ready_start", 32'(bus.tx_ready), 32'd1);
        load(8'h5A);
        chk("two_tx_ready_loaded", 32'(bus.tx_ready), 32'd0);
        spi_word(8'h01, 8, mi);
        chk("two_tx_ready_w1", 32'(bus.tx_ready), 32'd1);
        spi_word(8'h02, 8, mi2);
        chk("two_tx_ready_w2", 32'(bus.tx_ready), 32'd1);
        cs_high();
        chk("two_miso_w1", 32'(mi), 32'hA5);
        chk("two_miso_w2", 32'(mi2), 32'h5A);
        chk("two_rx_pulses", 32'(rx_cnt - rx_before), 32'd2);
        chk("two_rx_w1", 32'(rx_hist[rx_before]), 32'h01);
        chk("two_rx_w2", 32'(rx_hist[rx_before + 1]), 32'h02);

        // Underrun
        rx_before = rx_cnt;
        bus.cs_n = 1'b0;
        spi_word(8'h96, 8, mi);
        cs_high();
        chk("under_miso", 32'(mi), 32'h00);
        chk("under_rx_data", 32'(bus.rx_data), 32'h96);
        chk("under_rx_pulses", 32'(rx_cnt - rx_before), 32'd1);

        // Abort after 5 bits, then a good frame
        rx_before = rx_cnt;
        bus.cs_n = 1'b0;
        spi_word(8'hF0, 5, mi);
        cs_high();
        chk("abort_frame_err", 32'(fe_cnt), 32'd1);
        chk("abort_no_rx", 32'(rx_cnt - rx_before), 32'd0);
        chk("abort_rx_hold", 32'(bus.rx_data), 32'h96);
        chk("abort_state", 32'(bus.slave_state), 32'd0);
        bus.cs_n = 1'b0;
        spi_word(8'h71, 8, mi);
        cs_high();
        chk("after_abort_rx", 32'(bus.rx_data), 32'h71);
        chk("after_abort_pulses", 32'(rx_cnt - rx_before), 32'd1);
        chk("after_abort_fe", 32'(fe_cnt), 32'd1);

        // Reset mid-word with cs_n low
        rx_before = rx_cnt;
        bus.cs_n = 1'b0;
        spi_word(8'hFF, 3, mi);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(6);
        chk("rstmid_state", 32'(bus.slave_state), 32'd2);
        chk("rstmid_miso", 32'(bus.miso), 32'd0);
        chk("rstmid_rx_data", 32'(bus.rx_data), 32'h00);
        spi_word(8'hFF, 5, mi);
        wait_clk(6);
        chk("rstmid_state_hold", 32'(bus.slave_state), 32'd2);
        chk("rstmid_no_rx", 32'(rx_cnt - rx_before), 32'd0);
        chk("rstmid_no_fe", 32'(fe_cnt), 32'd1);
        cs_high();
        chk("rstmid_state_idle", 32'(bus.slave_state), 32'd0);
        load(8'h3E);
        bus.cs_n = 1'b0;
        spi_word(8'hC3, 8, mi);
        cs_high();
        chk("rstmid_miso_byte", 32'(mi), 32'h3E);
        chk("rstmid_rx_after", 32'(bus.rx_data), 32'hC3);
        chk("rstmid_rx_pulses", 32'(rx_cnt - rx_before), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Standalone SPI responder (slave end) for external SPI masters. Receives sclk/cs_n/mosi from off-block, oversamples them on the system clock, and drives miso.
- Supports all four cpol/cpha modes, MSB first, with back-to-back multi-byte frames.
- Presents each received byte on a parallel port with a one-cycle valid strobe, and accepts the next transmit byte via a load handshake.

Parameters:
- DATA_WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi (minimum 2).
- IDLE_BYTE, 8'h00, word shifted out when no tx word is pending at word start.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- cpol, input, 1, sclk idle level; sampled at frame start.
- cpha, input, 1, 0 = sample on leading edge, 1 = sample on trailing edge; sampled at frame start.
- sclk, input, 1, asynchronous serial clock from master.
- cs_n, input, 1, asynchronous chip select, active-low.
- mosi, input, 1, asynchronous serial data in.
- miso, output, 1, serial data out.
- tx_data, input, DATA_WIDTH, next word to transmit.
- tx_load, input, 1, captures tx_data when tx_ready=1.
- tx_ready, output, 1, pending tx register empty.
- rx_data, output, DATA_WIDTH, last complete received word.
- rx_valid, output, 1, one-cycle strobe when rx_data updates.
- frame_err, output, 1, one-cycle strobe when cs_n deasserts mid-word.
- slave_state, output, 2, FSM state: 0 IDLE, 1 XFER, 2 WAIT_CS.

Behaviour:
- **Reset values:** miso=0, tx_ready=1, rx_data=0, rx_valid=0, frame_err=0, slave_state=IDLE. Sync flops reset to sclk=0 and cs_n=1; bit counter and shift registers are 0.
- **Input sync and edge detection:**
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized sclk.
  - Leading edge = transition away from the latched cpol; trailing edge = transition back to it.
  - sclk edges are ignored outside XFER.
- **Timing constraint:** each sclk high or low phase must last at least SYNC_STAGES+2 clk cycles. Faster sclk is out of spec and behaviour is undefined.
- **IDLE:**
  - On a synchronized cs_n falling edge: latch cpol and cpha, and load tx_shift with the pending word (or IDLE_BYTE if tx_ready=1).
  - Mark the pending register empty, so tx_ready=1 on the next cycle.
  - Set miso = tx_shift MSB, clear the bit counter, go to XFER.
- **XFER:**
  - Sample edge (leading if cpha=0, trailing if cpha=1): shift the synchronized mosi into rx_shift LSB and increment the bit counter.
  - Shift edge (the opposite edge): shift tx_shift left and drive the new MSB on miso.
  - cpha=1 only: the first leading edge of each word does not shift, because its MSB is already on miso.
  - After DATA_WIDTH samples:
    - rx_data <= assembled word; rx_valid=1 for exactly one cycle, SYNC_STAGES+1 clk after the final sampling sclk edge at the pin.
    - Bit counter wraps to 0.
    - tx_shift reloads from the pending word (or IDLE_BYTE) and the pending register is emptied.
    - Remain in XFER for the next word.
  - Synchronized cs_n rising:
    - With bit counter = 0: go to IDLE quietly.
    - With bit counter != 0: discard the partial word, leave rx_data unchanged, pulse frame_err for 1 cycle, go to IDLE.
- **miso:** driven as 0 whenever state != XFER (no tristate).
- **TX handshake:**
  - tx_load with tx_ready=1 captures tx_data; tx_ready drops on the next cycle.
  - tx_load with tx_ready=0 is ignored and the pending word is not overwritten.
  - tx_load in the same cycle as a word-boundary reload: the reload takes the old pending word first. The new load is then accepted, because the register was freed that cycle and tx_ready is treated as 1.
- **WAIT_CS:**
  - Entered after reset deassertion if synchronized cs_n=0.
  - Ignores all activity until cs_n=1, then goes to IDLE. This prevents joining a frame mid-word.
- **Mid-operation changes:**
  - Async reset mid-frame clears everything immediately; there is no rx_valid and no frame_err.
  - cpol/cpha changes during XFER take no effect until the next frame start.

Test Plan:
- Mode 0 (cpol=0, cpha=0): tx_load 8'hD5 before frame; master sends 8'h3C with sclk period 20 clk. Required: rx_data=8'h3C with one rx_valid pulse, master receives 8'hD5 on miso, frame_err stays 0.
- Modes 1, 2 and 3 each: same exchange of 8'hDB (mosi) / 8'h24 (miso). Required: exact bytes in both directions; for cpha=1, miso MSB is stable before the first trailing edge.
- Two-word frame, cs_n held low: pending 8'hA5 then tx_load 8'h5A during word 1; mosi 8'h01, 8'h02. Required: two rx_valid pulses with rx_data 01 then 02, miso 8'hA5 then 8'h5A, tx_ready high after each reload.
- Underrun: no tx_load before frame. Required: miso carries IDLE_BYTE 8'h00 and the received word is still valid.
- Abort: cs_n rises after 5 sclk cycles. Required: frame_err pulses once, no rx_valid, rx_data holds its previous value; the next full frame is received correctly.
- Reset with cs_n low mid-word: required state WAIT_CS and miso=0; no reception until cs_n goes high and then falls again, after which the transfer proceeds normally.
